// File: rtl/display_scan_if.sv
// display_scan_if: digit-mux select/data, display masks and active-low display outputs of the scan driver.
interface display_scan_if;
    logic [1:0] mux_sel;
    logic [3:0] mux_data;
    logic [3:0] blank_mask;
    logic [3:0] blink_mask;
    logic       blink_en;
    logic [3:0] dp_mask;
    logic [3:0] an_n;
    logic [6:0] seg_n;
    logic       dp_n;
    modport master (
        output mux_sel, an_n, seg_n, dp_n,
        input  mux_data, blank_mask, blink_mask, blink_en, dp_mask
    );
    modport slave (
        input  mux_sel, an_n, seg_n, dp_n,
        output mux_data, blank_mask, blink_mask, blink_en, dp_mask
    );
endinterface

// File: rtl/display_scan_driver.sv
// display_scan_driver: 4-digit 7-segment scan with blanking, blinking, DP and anti-ghost guard time.
module display_scan_driver #(
    parameter int REFRESH_DIV  = 100000,
    parameter int GUARD        = 16,
    parameter int BLINK_FRAMES = 125
) (
    input  logic                  clk,
    input  logic                  rst_n,
    display_scan_if.master        disp_io
);
    localparam int PW = $clog2(REFRESH_DIV);
    localparam int FW = $clog2(BLINK_FRAMES + 1);
    logic [PW-1:0] presc_q, presc_d, guard_q, guard_d;
    logic [1:0]    idx_q, idx_d;
    logic [FW-1:0] frame_q, frame_d;
    logic          phase_q, phase_d;
    logic [3:0]    an_q, an_d;
    logic [6:0]    seg_q, seg_d;
    logic          dp_q, dp_d;
    logic          wrap, frame_tick, frame_last, dark;
    function automatic logic [6:0] dec(input logic [3:0] v);
        case (v)
            4'd0:    dec = 7'h40;
            4'd1:    dec = 7'h79;
            4'd2:    dec = 7'h24;
            4'd3:    dec = 7'h30;
            4'd4:    dec = 7'h19;
            4'd5:    dec = 7'h12;
            4'd6:    dec = 7'h02;
            4'd7:    dec = 7'h78;
            4'd8:    dec = 7'h00;
            4'd9:    dec = 7'h10;
            4'd15:   dec = 7'h7F;
            default: dec = 7'h3F;
        endcase
    endfunction
    always_comb begin
        wrap       = presc_q == PW'(REFRESH_DIV - 1);
        frame_tick = wrap && idx_q == 2'd3;
        frame_last = frame_q == FW'(BLINK_FRAMES - 1);
        presc_d    = wrap ? '0 : presc_q + 1'b1;
        idx_d      = wrap ? idx_q + 2'd1 : idx_q;
        guard_d    = wrap ? PW'(GUARD) : guard_q - PW'(guard_q != '0);
        // blink disabled parks the counter in the visible phase
        frame_d    = !disp_io.blink_en ? '0 : frame_tick ? (frame_last ? '0 : frame_q + 1'b1) : frame_q;
        phase_d    = disp_io.blink_en & (phase_q ^ (frame_tick & frame_last));
        dark       = (guard_q != '0) | disp_io.blank_mask[idx_q]
                   | (disp_io.blink_en & phase_q & disp_io.blink_mask[idx_q]);
        an_d       = dark ? 4'hF : ~(4'b0001 << idx_q);
        seg_d      = dark ? 7'h7F : dec(disp_io.mux_data);
        dp_d       = dark | ~disp_io.dp_mask[idx_q];
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            guard_q <= '0;
            idx_q   <= '0;
            frame_q <= '0;
            phase_q <= 1'b0;
            an_q    <= 4'hF;
            seg_q   <= 7'h7F;
            dp_q    <= 1'b1;
        end else begin
            presc_q <= presc_d;
            guard_q <= guard_d;
            idx_q   <= idx_d;
            frame_q <= frame_d;
            phase_q <= phase_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
            dp_q    <= dp_d;
        end
    end
    assign disp_io.mux_sel = idx_q;
    assign disp_io.an_n    = an_q;
    assign disp_io.seg_n   = seg_q;
    assign disp_io.dp_n    = dp_q;
endmodule
